// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_t : arbitration / issue / wait sequencing states
//   mem_owner_t : which requester owns the outstanding transaction
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    MEM_OWNER_IF   = 1'b0,
    MEM_OWNER_DATA = 1'b1
  } mem_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction outstanding: arbitrate (IDLE) -> issue (ISSUE) -> await
// response (WAIT). Data has priority; a streak counter forces a fetch grant
// after STREAK_MAX consecutive data grants taken while fetch was waiting.
// Ports:
//   clk_i, reset_ni              : clock, async active-low reset
//   if_req_i/if_addr_i           : fetch request; if_gnt_o/if_rvalid_o pulses
//   d_req_i/d_we_i/d_be_i/
//   d_addr_i/d_wdata_i           : data request; d_gnt_o/d_rvalid_o pulses
//   rdata_o                      : response data for either requester
//   mem_req_o + mem_*_o          : registered memory request and payload
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i                  : memory handshake and response
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned STREAK_W = $clog2(STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STREAK_MAX);

  arb_state_t            state_q, state_d;
  mem_owner_t            owner_q;
  logic [STREAK_W-1:0]   streak_q;
  logic                  fetch_win, data_win;
  logic                  if_grant, d_grant;

  // Arbitration on current inputs; fetch only beats data once the streak is spent.
  always_comb begin
    fetch_win = if_req_i && (!d_req_i || (streak_q == STREAK_LIMIT));
    data_win  = d_req_i && !fetch_win;
    if_grant  = (state_q == ARB_IDLE) && fetch_win;
    d_grant   = (state_q == ARB_IDLE) && data_win;
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= ARB_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic; handshakes outside their own state are ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (if_req_i || d_req_i) state_d = ARB_ISSUE;
      ARB_ISSUE: if (mem_gnt_i)           state_d = ARB_WAIT;
      ARB_WAIT:  if (mem_rvalid_i)        state_d = ARB_IDLE;
      default:                            state_d = ARB_IDLE;
    endcase
  end

  // Outputs; grants are masked while reset is held so nothing pulses in reset.
  always_comb begin
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    if_rvalid_o = 1'b0;
    d_rvalid_o  = 1'b0;
    mem_req_o   = (state_q == ARB_ISSUE);
    rdata_o     = mem_rdata_i;
    if (reset_ni) begin
      if_gnt_o = if_grant;
      d_gnt_o  = d_grant;
    end
    if ((state_q == ARB_WAIT) && mem_rvalid_i) begin
      if_rvalid_o = (owner_q == MEM_OWNER_IF);
      d_rvalid_o  = (owner_q == MEM_OWNER_DATA);
    end
  end

  // Owner and payload captured on the grant edge, held until the next grant.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      owner_q     <= MEM_OWNER_IF;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (if_grant) begin
      owner_q     <= MEM_OWNER_IF;
      mem_we_o    <= 1'b0;
      mem_be_o    <= {BE_W{1'b1}};
      mem_addr_o  <= if_addr_i;
      mem_wdata_o <= '0;
    end else if (d_grant) begin
      owner_q     <= MEM_OWNER_DATA;
      mem_we_o    <= d_we_i;
      mem_be_o    <= d_be_i;
      mem_addr_o  <= d_addr_i;
      mem_wdata_o <= d_wdata_i;
    end
  end

  // Streak of data grants taken while fetch was waiting.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      streak_q <= '0;
    end else if (if_grant) begin
      streak_q <= '0;
    end else if (d_grant) begin
      if (!if_req_i)                   streak_q <= '0;
      else if (streak_q != STREAK_LIMIT) streak_q <= streak_q + STREAK_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model compared every cycle,
// plus directed literal checks on the main scenarios.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = DATA_W / 8;
  localparam int unsigned STREAK_MAX = 4;

  logic              clk_i = 1'b0;
  logic              reset_ni = 1'b0;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic              if_gnt_o, if_rvalid_o;
  logic              d_req_i = 1'b0;
  logic              d_we_i = 1'b0;
  logic [BE_W-1:0]   d_be_i = '0;
  logic [ADDR_W-1:0] d_addr_i = '0;
  logic [DATA_W-1:0] d_wdata_i = '0;
  logic              d_gnt_o, d_rvalid_o;
  logic [DATA_W-1:0] rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i = 1'b0;
  logic              mem_rvalid_i = 1'b0;
  logic [DATA_W-1:0] mem_rdata_i = '0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STREAK_MAX(STREAK_MAX)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: is a transaction outstanding, has memory taken it,
  // who owns it, what payload it carries, and how many data grants in a row.
  bit                m_busy = 0;
  bit                m_taken = 0;
  bit                m_is_data = 0;
  logic              m_we = 0;
  logic [BE_W-1:0]   m_be = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  int                m_streak = 0;

  function automatic bit fetch_first();
    return if_req_i && (!d_req_i || m_streak >= int'(STREAK_MAX));
  endfunction

  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      m_busy = 0; m_taken = 0; m_is_data = 0;
      m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0; m_streak = 0;
    end else if (!m_busy) begin
      if (if_req_i || d_req_i) begin
        m_busy = 1; m_taken = 0;
        if (fetch_first()) begin
          m_is_data = 0; m_we = 0; m_be = '1; m_addr = if_addr_i; m_wdata = '0;
          m_streak = 0;
        end else begin
          m_is_data = 1; m_we = d_we_i; m_be = d_be_i; m_addr = d_addr_i; m_wdata = d_wdata_i;
          m_streak = if_req_i ? ((m_streak < int'(STREAK_MAX)) ? m_streak + 1 : m_streak) : 0;
        end
      end
    end else if (!m_taken) begin
      if (mem_gnt_i) m_taken = 1;
    end else if (mem_rvalid_i) begin
      m_busy = 0;
    end
  end

  // Grant log for order checks: bit i set means grant i went to fetch.
  bit          log_en = 0;
  int          grant_cnt = 0;
  logic [15:0] grant_bits = '0;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    logic exp_if_gnt, exp_d_gnt, arb;
    arb        = reset_ni && !m_busy;
    exp_if_gnt = arb && fetch_first();
    exp_d_gnt  = arb && d_req_i && !fetch_first();
    check("if_gnt",     if_gnt_o,    exp_if_gnt);
    check("d_gnt",      d_gnt_o,     exp_d_gnt);
    check("mem_req",    mem_req_o,   m_busy && !m_taken);
    check("if_rvalid",  if_rvalid_o, m_busy && m_taken && mem_rvalid_i && !m_is_data);
    check("d_rvalid",   d_rvalid_o,  m_busy && m_taken && mem_rvalid_i && m_is_data);
    check("rdata",      rdata_o,     mem_rdata_i);
    check("mem_we",     mem_we_o,    m_we);
    check("mem_be",     mem_be_o,    m_be);
    check("mem_addr",   mem_addr_o,  m_addr);
    check("mem_wdata",  mem_wdata_o, m_wdata);
    if (log_en && (if_gnt_o || d_gnt_o) && grant_cnt < 16) begin
      grant_bits[grant_cnt] = if_gnt_o;
      grant_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_grants(input int n);
    grant_cnt = 0; grant_bits = '0; log_en = 1;
    for (int i = 0; i < 300; i++) begin
      if (grant_cnt >= n) break;
      @(posedge clk_i);
    end
    #1;
    if_req_i = 0; d_req_i = 0; log_en = 0;
  endtask

  initial begin
    // Reset held with a request present: nothing may be granted.
    if_req_i = 1; if_addr_i = 32'h40;
    @(negedge clk_i);
    check("rst_if_gnt", if_gnt_o, 1'b0);
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_mem_be", mem_be_o, 4'h0);
    tick(); if_req_i = 0;
    tick(); reset_ni = 1;
    tick();

    // Fetch alone.
    if_req_i = 1; if_addr_i = 32'h100;
    @(negedge clk_i);
    check("t1_if_gnt", if_gnt_o, 1'b1);
    check("t1_d_gnt", d_gnt_o, 1'b0);
    tick(); if_req_i = 0; if_addr_i = '0; mem_gnt_i = 1;
    @(negedge clk_i);
    check("t1_mem_req", mem_req_o, 1'b1);
    check("t1_mem_we", mem_we_o, 1'b0);
    check("t1_mem_be", mem_be_o, 4'hF);
    check("t1_mem_addr", mem_addr_o, 32'h100);
    tick(); mem_gnt_i = 0;
    @(negedge clk_i);
    check("t1_c2_mem_req", mem_req_o, 1'b0);
    check("t1_c2_if_rvalid", if_rvalid_o, 1'b0);
    tick(); mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    check("t1_if_rvalid", if_rvalid_o, 1'b1);
    check("t1_rdata", rdata_o, 32'hDEADBEEF);
    check("t1_d_rvalid", d_rvalid_o, 1'b0);
    tick(); mem_rvalid_i = 0;

    // Simultaneous requests: store wins, fetch follows.
    if_req_i = 1; if_addr_i = 32'h180;
    d_req_i = 1; d_we_i = 1; d_be_i = 4'h3; d_addr_i = 32'h200; d_wdata_i = 32'h55AA;
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h0BADF00D;
    @(negedge clk_i);
    check("t2_d_gnt", d_gnt_o, 1'b1);
    check("t2_if_gnt", if_gnt_o, 1'b0);
    tick(); d_req_i = 0; d_we_i = 0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
    @(negedge clk_i);
    check("t2_mem_we", mem_we_o, 1'b1);
    check("t2_mem_be", mem_be_o, 4'h3);
    check("t2_mem_addr", mem_addr_o, 32'h200);
    check("t2_mem_wdata", mem_wdata_o, 32'h55AA);
    tick();
    @(negedge clk_i);
    check("t2_d_rvalid", d_rvalid_o, 1'b1);
    tick();
    @(negedge clk_i);
    check("t2_if_gnt_next", if_gnt_o, 1'b1);
    tick(); if_req_i = 0;
    tick(); tick();

    // Both held continuously: D,D,D,D,F,D,D,D,D,F.
    if_req_i = 1; if_addr_i = 32'h104;
    d_req_i = 1; d_we_i = 0; d_be_i = 4'hF; d_addr_i = 32'h300;
    run_grants(10);
    check("t3_grant_cnt", 64'(grant_cnt), 64'd10);
    check("t3_grant_order", 64'(grant_bits[9:0]), 64'h210);
    tick(); tick();
    mem_gnt_i = 0; mem_rvalid_i = 0;

    // Memory withholds its grant; payload held, spurious rvalid ignored.
    d_req_i = 1; d_we_i = 0; d_be_i = 4'hF; d_addr_i = 32'h300;
    if_req_i = 1; if_addr_i = 32'h108;
    @(negedge clk_i);
    check("t4_d_gnt", d_gnt_o, 1'b1);
    tick(); d_req_i = 0; d_addr_i = 32'h3FC;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) mem_rvalid_i = 1;
      @(negedge clk_i);
      check("t4_mem_req_held", mem_req_o, 1'b1);
      check("t4_mem_addr_held", mem_addr_o, 32'h300);
      check("t4_no_if_gnt", if_gnt_o, 1'b0);
      check("t4_no_d_rvalid", d_rvalid_o, 1'b0);
      tick(); mem_rvalid_i = 0;
    end
    mem_gnt_i = 1;
    @(negedge clk_i);
    check("t4_mem_req_late", mem_req_o, 1'b1);
    tick(); mem_gnt_i = 0;

    // Reset during WAIT (streak is 1 here); pending response dropped.
    #2 reset_ni = 0;
    @(negedge clk_i);
    check("t5_mem_req", mem_req_o, 1'b0);
    check("t5_if_gnt", if_gnt_o, 1'b0);
    check("t5_mem_addr", mem_addr_o, 32'h0);
    check("t5_mem_be", mem_be_o, 4'h0);
    tick(); mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE;
    @(negedge clk_i);
    check("t5_d_rvalid", d_rvalid_o, 1'b0);
    check("t5_if_rvalid", if_rvalid_o, 1'b0);
    tick();
    // Release with both requesting: a cleared streak gives four data grants first.
    d_req_i = 1; d_addr_i = 32'h400; mem_gnt_i = 1; reset_ni = 1;
    run_grants(5);
    check("t5_grant_cnt", 64'(grant_cnt), 64'd5);
    check("t5_grant_order", 64'(grant_bits[4:0]), 64'h10);
    tick(); tick(); tick();
    mem_gnt_i = 0; mem_rvalid_i = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
